// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch, writeback, execute-feedback and decoded-output bundle of the decode stage
// master: pipeline side (drives fetch/wb/ex inputs, receives _d outputs and hazard controls)
// slave : decode_stage itself
interface decode_stage_if;
  logic [31:0] instr_f;
  logic [31:0] pc_f;
  logic [31:0] pc_p_4_f;
  logic        flush_d;
  logic        register_write_wb;
  logic [4:0]  rd_wb;
  logic [31:0] result_wb;
  logic [4:0]  rd_ex;
  logic [1:0]  result_src_ex;
  logic [31:0] rs1_data_d;
  logic [31:0] rs2_data_d;
  logic [31:0] pc_d;
  logic [31:0] pc_p_4_d;
  logic [4:0]  rd_d;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [31:0] immediate_extend_d;
  logic        register_write_d;
  logic        mem_write_enable_d;
  logic        jump_d;
  logic        branch_d;
  logic        alu_src_d;
  logic [1:0]  result_src_d;
  logic [4:0]  alu_control_d;
  logic        illegal_instr_d;
  logic        stall_f;
  logic        stall_d;
  logic        bubble_ex;
  modport master (
    output instr_f, pc_f, pc_p_4_f, flush_d, register_write_wb, rd_wb, result_wb, rd_ex, result_src_ex,
    input  rs1_data_d, rs2_data_d, pc_d, pc_p_4_d, rd_d, rs1_d, rs2_d, immediate_extend_d,
           register_write_d, mem_write_enable_d, jump_d, branch_d, alu_src_d, result_src_d,
           alu_control_d, illegal_instr_d, stall_f, stall_d, bubble_ex
  );
  modport slave (
    input  instr_f, pc_f, pc_p_4_f, flush_d, register_write_wb, rd_wb, result_wb, rd_ex, result_src_ex,
    output rs1_data_d, rs2_data_d, pc_d, pc_p_4_d, rd_d, rs1_d, rs2_d, immediate_extend_d,
           register_write_d, mem_write_enable_d, jump_d, branch_d, alu_src_d, result_src_d,
           alu_control_d, illegal_instr_d, stall_f, stall_d, bubble_ex
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage - F/D register, 32x32 register file, control decoder, immediate extender
// Ports: clk, reset (async, active-high); bus (decode_stage_if.slave) carries fetch inputs,
// writeback port, execute feedback (rd_ex/result_src_ex), decoded _d outputs and stall/bubble controls.
// Option: define DECODE_HAZARD_UNIT_EN to compile in load-use hazard detection.
module decode_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  logic [31:0] instr_d;
  logic [31:0] rf [32];
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign op = instr_d[6:0];
  assign f3 = instr_d[14:12];
  assign f7 = instr_d[30];
  assign bus.rd_d  = instr_d[11:7];
  assign bus.rs1_d = instr_d[19:15];
  assign bus.rs2_d = instr_d[24:20];
  assign imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
  assign imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign imm_b = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
  assign imm_u = {instr_d[31:12], 12'b0};
  assign imm_j = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      instr_d      <= NOP_INSTR;
      bus.pc_d     <= RESET_PC;
      bus.pc_p_4_d <= RESET_PC + 32'd4;
    end else if (!bus.stall_d) begin
      instr_d      <= bus.flush_d ? NOP_INSTR : bus.instr_f;
      bus.pc_d     <= bus.pc_f;
      bus.pc_p_4_d <= bus.pc_p_4_f;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.register_write_wb && bus.rd_wb != 5'd0) begin
      rf[bus.rd_wb] <= bus.result_wb;
    end
  // rd_wb == rsN with rsN != 0 already implies rd_wb != 0, so the bypass needs no extra x0 test
  assign bus.rs1_data_d = bus.rs1_d == 5'd0 ? 32'd0 :
                          (bus.register_write_wb && bus.rd_wb == bus.rs1_d) ? bus.result_wb : rf[bus.rs1_d];
  assign bus.rs2_data_d = bus.rs2_d == 5'd0 ? 32'd0 :
                          (bus.register_write_wb && bus.rd_wb == bus.rs2_d) ? bus.result_wb : rf[bus.rs2_d];
  function automatic logic [4:0] alu_op(input logic [2:0] f, input logic sub, input logic sra);
    return f == 3'b000 ? (sub ? 5'd1 : 5'd0) :
           f == 3'b001 ? 5'd5 :
           f == 3'b010 ? 5'd8 :
           f == 3'b011 ? 5'd9 :
           f == 3'b100 ? 5'd4 :
           f == 3'b101 ? (sra ? 5'd7 : 5'd6) :
           f == 3'b110 ? 5'd3 : 5'd2;
  endfunction
  // funct3 1xx maps onto BLT..BGEU (14..17); 0x0/0x1 onto BEQ/BNE
  function automatic logic [4:0] br_op(input logic [2:0] f);
    return f[2] ? 5'd14 + {3'b000, f[1:0]} : (f[0] ? 5'd13 : 5'd12);
  endfunction
  always_comb begin
    bus.register_write_d   = 1'b0;
    bus.mem_write_enable_d = 1'b0;
    bus.jump_d             = 1'b0;
    bus.branch_d           = 1'b0;
    bus.alu_src_d          = 1'b0;
    bus.result_src_d       = 2'b00;
    bus.alu_control_d      = 5'd0;
    bus.illegal_instr_d    = 1'b0;
    bus.immediate_extend_d = 32'd0;
    case (op)
      7'b0110011: begin
        bus.register_write_d = 1'b1;
        bus.alu_control_d    = alu_op(f3, f7, f7);
      end
      7'b0010011: begin
        bus.register_write_d   = 1'b1;
        bus.alu_src_d          = 1'b1;
        bus.alu_control_d      = alu_op(f3, 1'b0, f7);
        bus.immediate_extend_d = imm_i;
      end
      7'b0000011: begin
        bus.register_write_d   = 1'b1;
        bus.alu_src_d          = 1'b1;
        bus.result_src_d       = 2'b01;
        bus.immediate_extend_d = imm_i;
      end
      7'b0100011: begin
        bus.mem_write_enable_d = 1'b1;
        bus.alu_src_d          = 1'b1;
        bus.immediate_extend_d = imm_s;
      end
      7'b1100011: begin
        bus.branch_d           = 1'b1;
        bus.alu_control_d      = br_op(f3);
        bus.immediate_extend_d = imm_b;
      end
      7'b1101111: begin
        bus.jump_d             = 1'b1;
        bus.register_write_d   = 1'b1;
        bus.result_src_d       = 2'b10;
        bus.immediate_extend_d = imm_j;
      end
      7'b1100111: begin
        bus.jump_d             = 1'b1;
        bus.register_write_d   = 1'b1;
        bus.alu_src_d          = 1'b1;
        bus.result_src_d       = 2'b10;
        bus.immediate_extend_d = imm_i;
      end
      7'b0110111: begin
        bus.register_write_d   = 1'b1;
        bus.alu_src_d          = 1'b1;
        bus.alu_control_d      = 5'd10;
        bus.immediate_extend_d = imm_u;
      end
      7'b0010111: begin
        bus.register_write_d   = 1'b1;
        bus.alu_src_d          = 1'b1;
        bus.alu_control_d      = 5'd11;
        bus.immediate_extend_d = imm_u;
      end
      default: bus.illegal_instr_d = 1'b1;
    endcase
  end
`ifdef DECODE_HAZARD_UNIT_EN
  logic lwstall;
  assign lwstall = !reset && bus.result_src_ex == 2'b01 && bus.rd_ex != 5'd0 &&
                   (bus.rd_ex == bus.rs1_d || bus.rd_ex == bus.rs2_d);
  assign bus.stall_f   = lwstall;
  assign bus.stall_d   = lwstall;
  assign bus.bubble_ex = lwstall || (bus.flush_d && !reset);
`else
  logic unused_ex;
  assign unused_ex     = ^{bus.rd_ex, bus.result_src_ex};
  assign bus.stall_f   = 1'b0;
  assign bus.stall_d   = 1'b0;
  assign bus.bubble_ex = bus.flush_d && !reset;
`endif
endmodule
